// File: rtl/lc3b_types.sv
// Shared LC-3b types: pmem line/address widths and the pmem responder state encoding.
package lc3b_types;

    typedef logic [127:0] lc3b_pmem_line;
    typedef logic [15:0]  lc3b_pmem_addr;

    localparam int PMEM_LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        PMEM_IDLE,
        PMEM_WAIT,
        PMEM_RESP,
        PMEM_RECOVER
    } lc3b_pmem_state;

endpackage

// File: rtl/pmem_line_array.sv
// Line store: synchronous write, registered read of the addressed line every cycle.
// One-cycle read latency; no flow control, the caller owns index stability.
module pmem_line_array
    import lc3b_types::*;
#(
    parameter  int DEPTH_LINES = 64,
    localparam int IW          = $clog2(DEPTH_LINES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] index,
    input  lc3b_pmem_line wdata,
    output lc3b_pmem_line rdata
);

    lc3b_pmem_line mem [DEPTH_LINES];
    lc3b_pmem_line rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata_q <= mem[index];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// Line-granular pmem responder: one request at a time, pmem_resp LATENCY cycles after acceptance.
// Requests are level-held; dropping the accepted line mid-wait aborts, requests in RECOVER are ignored.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pmem_read,
    input  logic          pmem_write,
    input  lc3b_pmem_addr pmem_address,
    input  lc3b_pmem_line pmem_wdata,
    output logic          pmem_resp,
    output lc3b_pmem_line pmem_rdata,
    output logic          busy,
    output logic          protocol_err
);

    localparam int       IW       = $clog2(DEPTH_LINES);
    localparam bit [7:0] CNT_INIT = 8'(LATENCY - 1);

    lc3b_pmem_state state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           op_wr_q, op_wr_d;
    logic [IW-1:0]  idx_q, idx_d;
    lc3b_pmem_line  wdata_q, wdata_d;
    logic           err_q, err_d;
    lc3b_pmem_line  rdata_q, rdata_d;

    logic [IW-1:0]  addr_idx;
    logic [IW-1:0]  arr_index;
    lc3b_pmem_line  arr_rdata;
    logic           arr_we;
    logic           req_any;
    logic           req_live;
    logic           unused_addr;

    assign addr_idx    = pmem_address[PMEM_LINE_OFFSET_BITS +: IW];
    assign unused_addr = ^pmem_address;
    assign req_any     = pmem_read | pmem_write;
    assign req_live    = op_wr_q ? pmem_write : pmem_read;

    // In IDLE the array reads the incoming address so the line is ready even when LATENCY=1.
    assign arr_index = (state_q == PMEM_IDLE) ? addr_idx : idx_q;
    assign arr_we    = (state_q == PMEM_RESP) && op_wr_q;

    pmem_line_array #(
        .DEPTH_LINES (DEPTH_LINES)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .index (arr_index),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            PMEM_IDLE: begin
                if (req_any) begin
                    op_wr_d = pmem_write;
                    idx_d   = addr_idx;
                    wdata_d = pmem_wdata;
                    if (pmem_read && pmem_write) begin
                        err_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d = PMEM_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = PMEM_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            PMEM_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (!req_live) begin
                    state_d = PMEM_IDLE;
                    cnt_d   = '0;
                end else if (cnt_d == 8'd0) begin
                    state_d = PMEM_RESP;
                end
            end
            PMEM_RESP:    state_d = PMEM_RECOVER;
            PMEM_RECOVER: state_d = PMEM_IDLE;
            default:      state_d = PMEM_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if ((state_q == PMEM_RESP) && !op_wr_q) begin
            rdata_d = arr_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PMEM_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign pmem_resp    = (state_q == PMEM_RESP);
    assign pmem_rdata   = rdata_d;
    // The cycle in which an IDLE request is about to be accepted already counts as busy.
    assign busy         = rst_n && ((state_q != PMEM_IDLE) || req_any);
    assign protocol_err = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: one LATENCY=10 instance and one LATENCY=1 instance.
module tb_pmem_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         rd1 = 1'b0, wr1 = 1'b0;
    logic [15:0]  addr1 = '0;
    logic [127:0] wd1 = '0;
    logic         resp1, busy1, err1;
    logic [127:0] rdata1;

    logic         rd2 = 1'b0, wr2 = 1'b0;
    logic [15:0]  addr2 = '0;
    logic [127:0] wd2 = '0;
    logic         resp2, busy2, err2;
    logic [127:0] rdata2;

    int nvec = 0;
    int nerr = 0;

    localparam logic [127:0] LINE0 = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] LA    = 128'hAAAA0000_1111AAAA_2222AAAA_3333AAAA;
    localparam logic [127:0] LB    = 128'hBBBB0000_1111BBBB_2222BBBB_3333BBBB;
    localparam logic [127:0] LC    = 128'hCCCC0000_1111CCCC_2222CCCC_3333CCCC;
    localparam logic [127:0] LD    = 128'hDDDD0000_1111DDDD_2222DDDD_3333DDDD;
    localparam logic [127:0] LP    = 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5;
    localparam logic [127:0] LE    = 128'hEEEE0000_1111EEEE_2222EEEE_3333EEEE;
    localparam logic [127:0] LF    = 128'hFFFF0000_1111FFFF_2222FFFF_3333FFFF;
    localparam logic [127:0] LG    = 128'h6666_7777_8888_9999_0000_1111_2222_3333;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(10), .DEPTH_LINES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr1), .pmem_wdata(wd1),
        .pmem_resp(resp1), .pmem_rdata(rdata1), .busy(busy1), .protocol_err(err1)
    );

    pmem_responder #(.LATENCY(1), .DEPTH_LINES(64)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .pmem_read(rd2), .pmem_write(wr2), .pmem_address(addr2), .pmem_wdata(wd2),
        .pmem_resp(resp2), .pmem_rdata(rdata2), .busy(busy2), .protocol_err(err2)
    );

    // Drives one request on the selected instance and reports what was observed at each negedge.
    // k=0 is the cycle whose rising edge accepts the request; the request drops 'hold' cycles after resp.
    task automatic txn(input bit sel, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [127:0] d, input int hold,
                       output int lat, output int nbusy, output int nresp, output logic [127:0] rdat);
        int drop_at;
        logic r, b;
        lat = -1; nbusy = 0; nresp = 0; rdat = 'x; drop_at = -10;
        @(negedge clk);
        if (sel) begin rd2 = rd; wr2 = wr; addr2 = a; wd2 = d; end
        else     begin rd1 = rd; wr1 = wr; addr1 = a; wd1 = d; end
        #1;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            r = sel ? resp2 : resp1;
            b = sel ? busy2 : busy1;
            if (b) nbusy++;
            if (r) begin
                nresp++;
                if (lat < 0) begin
                    lat = k;
                    rdat = sel ? rdata2 : rdata1;
                    drop_at = k + hold;
                end
            end
            if (k == drop_at) begin
                rd1 = 1'b0; wr1 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
            end
            if (lat >= 0 && k >= drop_at + 3) break;
        end
        rd1 = 1'b0; wr1 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        nvec++; if (resp1 !== 1'b0) begin nerr++; $display("FAIL reset_resp got %b want 0", resp1); end
        nvec++; if (rdata1 !== 128'h0) begin nerr++; $display("FAIL reset_rdata got %h want 0", rdata1); end
        nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy1); end
        nvec++; if (err1 !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", err1); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int lat, nb, nr;
        logic [127:0] rd;
        txn(1'b0, 1'b0, 1'b1, 16'h0040, LINE0, 0, lat, nb, nr, rd);
        nvec++; if (lat !== 10) begin nerr++; $display("FAIL wr_latency got %0d want 10", lat); end
        nvec++; if (nb !== 12) begin nerr++; $display("FAIL wr_busy got %0d want 12", nb); end
        txn(1'b0, 1'b1, 1'b0, 16'h0040, '0, 0, lat, nb, nr, rd);
        nvec++; if (lat !== 10) begin nerr++; $display("FAIL rd_latency got %0d want 10", lat); end
        nvec++; if (nb !== 12) begin nerr++; $display("FAIL rd_busy got %0d want 12", nb); end
        nvec++; if (nr !== 1) begin nerr++; $display("FAIL rd_resp_count got %0d want 1", nr); end
        nvec++; if (rd !== LINE0) begin nerr++; $display("FAIL rd_data got %h want %h", rd, LINE0); end
    endtask

    task automatic test_alias;
        int lat, nb, nr;
        logic [127:0] rd;
        txn(1'b0, 1'b0, 1'b1, 16'h0010, LA, 0, lat, nb, nr, rd);
        txn(1'b0, 1'b0, 1'b1, 16'h0410, LB, 0, lat, nb, nr, rd);
        txn(1'b0, 1'b1, 1'b0, 16'h0010, '0, 0, lat, nb, nr, rd);
        nvec++; if (rd !== LB) begin nerr++; $display("FAIL alias_data got %h want %h", rd, LB); end
        nvec++; if (err1 !== 1'b0) begin nerr++; $display("FAIL alias_err got %b want 0", err1); end
        txn(1'b0, 1'b0, 1'b1, 16'h0070, LG, 0, lat, nb, nr, rd);
        nvec++; if (rdata1 !== LB) begin nerr++; $display("FAIL rdata_hold_after_write got %h want %h", rdata1, LB); end
    endtask

    task automatic test_both_high;
        int lat, nb, nr;
        logic [127:0] rd;
        txn(1'b0, 1'b1, 1'b1, 16'h0020, LC, 0, lat, nb, nr, rd);
        nvec++; if (lat !== 10) begin nerr++; $display("FAIL both_latency got %0d want 10", lat); end
        nvec++; if (err1 !== 1'b1) begin nerr++; $display("FAIL both_err got %b want 1", err1); end
        txn(1'b0, 1'b1, 1'b0, 16'h0020, '0, 0, lat, nb, nr, rd);
        nvec++; if (rd !== LC) begin nerr++; $display("FAIL both_readback got %h want %h", rd, LC); end
        nvec++; if (err1 !== 1'b1) begin nerr++; $display("FAIL err_sticky got %b want 1", err1); end
    endtask

    task automatic test_abort;
        int lat, nb, nr;
        logic [127:0] rd;
        txn(1'b0, 1'b0, 1'b1, 16'h0030, LP, 0, lat, nb, nr, rd);
        nr = 0;
        @(negedge clk); wr1 = 1'b1; addr1 = 16'h0030; wd1 = LD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp1) nr++;
        end
        wr1 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (resp1) nr++;
        end
        nvec++; if (nr !== 0) begin nerr++; $display("FAIL abort_resp got %0d want 0", nr); end
        nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL abort_busy got %b want 0", busy1); end
        txn(1'b0, 1'b1, 1'b0, 16'h0030, '0, 0, lat, nb, nr, rd);
        nvec++; if (rd !== LP) begin nerr++; $display("FAIL abort_data got %h want %h", rd, LP); end
    endtask

    task automatic test_reset_mid_wait;
        int lat, nb, nr;
        logic [127:0] rd;
        txn(1'b0, 1'b0, 1'b1, 16'h0050, LE, 0, lat, nb, nr, rd);
        @(negedge clk); wr1 = 1'b1; addr1 = 16'h0050; wd1 = LF;
        repeat (3) @(negedge clk);
        nvec++; if (busy1 !== 1'b1) begin nerr++; $display("FAIL midwait_busy got %b want 1", busy1); end
        rst_n = 1'b0;
        #1;
        nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy1); end
        nvec++; if (resp1 !== 1'b0) begin nerr++; $display("FAIL rst_resp got %b want 0", resp1); end
        nvec++; if (err1 !== 1'b0) begin nerr++; $display("FAIL rst_err got %b want 0", err1); end
        nvec++; if (rdata1 !== 128'h0) begin nerr++; $display("FAIL rst_rdata got %h want 0", rdata1); end
        wr1 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 1'b1, 1'b0, 16'h0050, '0, 0, lat, nb, nr, rd);
        nvec++; if (rd !== LE) begin nerr++; $display("FAIL rst_line_data got %h want %h", rd, LE); end
    endtask

    task automatic test_latency_one;
        int lat, nb, nr;
        logic [127:0] rd;
        txn(1'b1, 1'b0, 1'b1, 16'h0060, LG, 0, lat, nb, nr, rd);
        nvec++; if (lat !== 1) begin nerr++; $display("FAIL l1_wr_latency got %0d want 1", lat); end
        txn(1'b1, 1'b1, 1'b0, 16'h0060, '0, 1, lat, nb, nr, rd);
        nvec++; if (lat !== 1) begin nerr++; $display("FAIL l1_rd_latency got %0d want 1", lat); end
        nvec++; if (nr !== 1) begin nerr++; $display("FAIL l1_resp_count got %0d want 1", nr); end
        nvec++; if (nb !== 3) begin nerr++; $display("FAIL l1_busy got %0d want 3", nb); end
        nvec++; if (rd !== LG) begin nerr++; $display("FAIL l1_data got %h want %h", rd, LG); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_alias;
        test_both_high;
        test_abort;
        test_reset_mid_wait;
        test_latency_one;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Line-granular physical-memory responder: the far end of the pmem_* interface that the L1 cache drives.
- Accepts one 128-bit line read or write at a time, waits a programmable latency, then pulses pmem_resp.
- Used as the synthesizable main-memory model under the cache in simulation and FPGA bring-up.
- Holds DEPTH_LINES lines; the address wraps modulo the depth.

Parameters:
- LATENCY, 10, cycles from request acceptance to pmem_resp (legal range 1..255).
- DEPTH_LINES, 64, number of 128-bit lines stored (power of 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pmem_read  in  1  line read request; level, held until pmem_resp.
- pmem_write  in  1  line write request; level, held until pmem_resp.
- pmem_address  in  16 (lc3b_pmem_addr)  byte address; bits [3:0] ignored; line index = addr[4+:log2(DEPTH_LINES)].
- pmem_wdata  in  128 (lc3b_pmem_line)  write line.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  128 (lc3b_pmem_line)  read line; valid in the pmem_resp cycle and held afterwards.
- busy  out  1  high from acceptance through the RECOVER state.
- protocol_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values (async, while rst_n=0): state=IDLE, pmem_resp=0, pmem_rdata=0, busy=0, protocol_err=0, latency counter=0.
- The storage array is not reset; reading an unwritten line returns X/undefined.
- IDLE:
  - If pmem_read or pmem_write is high at a rising edge, the request is accepted: op, index and wdata are captured, counter=LATENCY-1, go to WAIT.
  - If both are high: write wins and protocol_err is set.
- WAIT:
  - Counter decrements each cycle.
  - If the accepted request line (read or write, whichever was accepted) is low at an edge, the transaction aborts: no array write, no resp, go to IDLE. protocol_err is not set.
  - When the counter reaches 0, go to RESP.
- RESP (one cycle):
  - pmem_resp=1.
  - Read: pmem_rdata = array[captured index], registered so it is valid in this cycle.
  - Write: array[captured index] is written with the captured wdata at the edge ending this cycle.
  - Next state is RECOVER.
- RECOVER (one cycle):
  - Requests are ignored so a requester that drops its request the cycle after resp is not re-accepted.
  - Next state is IDLE.
- Latency: resp asserts exactly LATENCY cycles after the acceptance edge. LATENCY=1 means resp in the cycle after acceptance (the WAIT state is skipped).
- Back-to-back: minimum spacing between consecutive acceptances is LATENCY+2 cycles.
- Address/wdata changes after acceptance are ignored (captured values are used).
- Address wrap: index uses only the low log2(DEPTH_LINES) bits above bit 3; upper bits are ignored, no error.
- Read-after-write to the same line in consecutive transactions returns the new data.
- Reset mid-WAIT: transaction discarded, array untouched, outputs forced to reset values immediately (async).
- pmem_rdata changes only in the RESP cycle of a read; writes do not disturb it.

Decomposition:
- lc3b_types (shared package) gains:
  - lc3b_pmem_state enum {PMEM_IDLE, PMEM_WAIT, PMEM_RESP, PMEM_RECOVER}.
  - Constant PMEM_LINE_OFFSET_BITS = 4.
- Existing lc3b_pmem_line and lc3b_pmem_addr types are reused.
- One sub-module, pmem_line_array:
  - DEPTH_LINES x 128 synchronous-write, registered-read storage.
  - Ports: clk, we, index, wdata, rdata.
- FSM, counter and error logic stay in pmem_responder.

Test Plan:
1. Write 0x0123...CDEF (128-bit) to 0x0040, then read 0x0040, LATENCY=10 -> each pmem_resp arrives exactly 10 cycles after its acceptance edge; read returns the written line; busy high for 12 cycles per transaction.
2. Write line A to 0x0010, then line B to 0x0410 (DEPTH_LINES=64 aliases to index 1), then read 0x0010 -> returns B; protocol_err=0.
3. Raise pmem_read and pmem_write together with address 0x0020 and data C -> write of C is performed; protocol_err=1 and stays 1; a later read of 0x0020 returns C.
4. Start a write of D to 0x0030, drop pmem_write after 4 cycles -> no pmem_resp; a later read of 0x0030 returns the prior contents (not D).
5. Assert rst_n=0 mid-WAIT of a write, release it, then read the same line -> pmem_resp and busy go 0 immediately on reset assertion; the line is unchanged.
6. LATENCY=1, requester holds pmem_read one cycle past resp -> pmem_resp in the cycle after acceptance; the held request is not re-accepted during RECOVER; exactly one resp pulse.
